// File: rtl/rgb8_to_fp32_feeder_if.sv
// Pixel input handshake plus converted-pixel output bus of the RGB8 -> fp32 feeder.
//   in_valid / in_ready / in_pixel : packed {R,G,B} 8-bit pixel handshake
//   R / G / B                      : fp32 channel values presented to the HSV core
//   out_valid / out_first          : hold window of the presented pixel, pulse on its first cycle
//   pix_cnt / frame_done           : pixel index in frame, pulse on the last hold cycle of a frame
// master = pixel source / HSV-core side, slave = feeder.
interface rgb8_to_fp32_feeder_if #(
    parameter int CW = 14
);
    logic          in_valid;
    logic          in_ready;
    logic [23:0]   in_pixel;
    logic [31:0]   R;
    logic [31:0]   G;
    logic [31:0]   B;
    logic          out_valid;
    logic          out_first;
    logic [CW-1:0] pix_cnt;
    logic          frame_done;

    modport master (
        output in_valid, in_pixel,
        input  in_ready, R, G, B, out_valid, out_first, pix_cnt, frame_done
    );

    modport slave (
        input  in_valid, in_pixel,
        output in_ready, R, G, B, out_valid, out_first, pix_cnt, frame_done
    );
endinterface

// File: rtl/rgb8_to_fp32_feeder.sv
// Upstream stage of the RGB->HSV core. Accepts one packed 8-bit RGB pixel, converts
// each channel (one per cycle) to an exact IEEE-754 single, then presents all three
// channels together for HOLD_CYCLES clocks. Counts pixels per frame of HEIGHT*WIDTH.
// Ports:
//   Clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : rgb8_to_fp32_feeder_if.slave (pixel handshake in, fp32 pixel + frame status out)
module rgb8_to_fp32_feeder #(
    parameter int HEIGHT      = 100,
    parameter int WIDTH       = 100,
    parameter int HOLD_CYCLES = 6,
    parameter int CW          = 14
) (
    input  logic                        Clk,
    input  logic                        reset,
    rgb8_to_fp32_feeder_if.slave        bus
);
    localparam int DIM = HEIGHT * WIDTH;
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
    // Cycle before the last hold cycle; only meaningful when HOLD_CYCLES > 1.
    localparam logic [HW-1:0] HOLD_PRELAST = HW'((HOLD_CYCLES > 1) ? (HOLD_CYCLES - 2) : 0);
    localparam logic [CW-1:0] PIX_LAST     = CW'(DIM - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_R = 3'd1,
        CONV_G = 3'd2,
        CONV_B = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t        state_r;
    logic [23:0]   pix_r;
    logic [31:0]   r_sh_r;
    logic [31:0]   g_sh_r;
    logic [31:0]   r_out_r;
    logic [31:0]   g_out_r;
    logic [31:0]   b_out_r;
    logic          out_valid_r;
    logic          out_first_r;
    logic          frame_done_r;
    logic [CW-1:0] pix_cnt_r;
    logic [HW-1:0] hold_cnt_r;
    logic          last_pix_s;

    // Exact unsigned 8-bit integer to fp32: the value's leading one becomes the
    // implicit bit, the remaining low bits are left-aligned into the mantissa.
    function automatic logic [31:0] u8_to_fp32(input logic [7:0] v);
        logic [2:0]  p;
        logic [22:0] mant;
        logic [7:0]  expo;
        logic [31:0] res;
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                p = 3'(i);
            end
        end
        mant = {15'd0, v} << (5'd23 - {2'd0, p});
        expo = 8'd127 + {5'd0, p};
        if (v == 8'd0) begin
            res = 32'h0000_0000;
        end else begin
            res = {1'b0, expo, mant};
        end
        return res;
    endfunction

    assign last_pix_s = (pix_cnt_r == PIX_LAST);

    // Pixel FSM: accept, convert R/G/B on successive cycles, then hold the result.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_r      <= IDLE;
            pix_r        <= 24'd0;
            r_sh_r       <= 32'd0;
            g_sh_r       <= 32'd0;
            r_out_r      <= 32'd0;
            g_out_r      <= 32'd0;
            b_out_r      <= 32'd0;
            out_valid_r  <= 1'b0;
            out_first_r  <= 1'b0;
            frame_done_r <= 1'b0;
            pix_cnt_r    <= {CW{1'b0}};
            hold_cnt_r   <= {HW{1'b0}};
        end else begin
            out_first_r  <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // in_ready is high whenever we are here out of reset.
                    if (bus.in_valid) begin
                        pix_r   <= bus.in_pixel;
                        state_r <= CONV_R;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONV_R: begin
                    r_sh_r  <= u8_to_fp32(pix_r[23:16]);
                    state_r <= CONV_G;
                end
                CONV_G: begin
                    g_sh_r  <= u8_to_fp32(pix_r[15:8]);
                    state_r <= CONV_B;
                end
                CONV_B: begin
                    // All three channels update on the same edge so the core never
                    // sees a mix of two pixels.
                    r_out_r      <= r_sh_r;
                    g_out_r      <= g_sh_r;
                    b_out_r      <= u8_to_fp32(pix_r[7:0]);
                    out_valid_r  <= 1'b1;
                    out_first_r  <= 1'b1;
                    hold_cnt_r   <= {HW{1'b0}};
                    frame_done_r <= (HOLD_CYCLES == 1) && last_pix_s;
                    state_r      <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        out_valid_r <= 1'b0;
                        hold_cnt_r  <= {HW{1'b0}};
                        pix_cnt_r   <= last_pix_s ? {CW{1'b0}} : (pix_cnt_r + CW'(1));
                        state_r     <= IDLE;
                    end else begin
                        hold_cnt_r   <= hold_cnt_r + HW'(1);
                        // Registered, so raised one cycle early to land on the last hold cycle.
                        frame_done_r <= (hold_cnt_r == HOLD_PRELAST) && last_pix_s;
                        state_r      <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_r == IDLE) && !reset;
    assign bus.R          = r_out_r;
    assign bus.G          = g_out_r;
    assign bus.B          = b_out_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_first  = out_first_r;
    assign bus.pix_cnt    = pix_cnt_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_rgb8_to_fp32_feeder.sv
// Directed bench for rgb8_to_fp32_feeder: a default-size instance for conversion,
// latency, hold timing, backpressure and reset; a 2x2-frame instance for frame wrap.
module tb_rgb8_to_fp32_feeder;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    rgb8_to_fp32_feeder_if #(.CW(14)) bus  ();
    rgb8_to_fp32_feeder_if #(.CW(2))  bus2 ();

    rgb8_to_fp32_feeder #(.HEIGHT(100), .WIDTH(100), .HOLD_CYCLES(6), .CW(14)) dut (
        .Clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rgb8_to_fp32_feeder #(.HEIGHT(2), .WIDTH(2), .HOLD_CYCLES(6), .CW(2)) dut_small (
        .Clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Bounded wait for the feeder to return to IDLE.
    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            step();
            k++;
        end
        check_eq("ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    // Present one pixel from IDLE and check latency plus converted values.
    task automatic send_check(input string tag, input logic [23:0] pix,
                              input logic [31:0] er, input logic [31:0] eg,
                              input logic [31:0] eb, input logic [31:0] ecnt);
        bus.in_pixel = pix;
        bus.in_valid = 1'b1;
        check_eq({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_pixel = 24'h5A_5A_5A;
        for (int k = 1; k < 4; k++) begin
            check_eq({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
            step();
        end
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_first"}, 32'(bus.out_first), 32'd1);
        check_eq({tag, "_R"}, bus.R, er);
        check_eq({tag, "_G"}, bus.G, eg);
        check_eq({tag, "_B"}, bus.B, eb);
        check_eq({tag, "_cnt"}, 32'(bus.pix_cnt), ecnt);
    endtask

    logic [23:0] pix4  [3];
    logic [31:0] exp4r [3];
    logic [31:0] exp4g [3];
    logic [31:0] exp4b [3];

    initial begin
        int nv, nr, nf, bad, stab, np, nfd, fd_pos;
        logic acc_pending;
        logic [95:0] prev;

        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = 24'd0;
        bus2.in_valid = 1'b0;
        bus2.in_pixel = 24'd0;
        pix4[0] = 24'h01_02_04; exp4r[0] = 32'h3F800000; exp4g[0] = 32'h40000000; exp4b[0] = 32'h40800000;
        pix4[1] = 24'h10_20_40; exp4r[1] = 32'h41800000; exp4g[1] = 32'h42000000; exp4b[1] = 32'h42800000;
        pix4[2] = 24'h80_FF_00; exp4r[2] = 32'h43000000; exp4g[2] = 32'h437F0000; exp4b[2] = 32'h00000000;

        // Reset state
        step();
        step();
        check_eq("rst_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_R", bus.R, 32'd0);
        check_eq("rst_cnt", 32'(bus.pix_cnt), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rel_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Conversion and latency
        send_check("conv", 24'hFF_80_01, 32'h437F0000, 32'h43000000, 32'h3F800000, 32'd0);
        wait_ready();
        send_check("zero", 24'h00_64_03, 32'h00000000, 32'h42C80000, 32'h40400000, 32'd1);
        wait_ready();

        // Hold timing with in_valid held high for three pixels
        nv = 0; nr = 0; nf = 0; bad = 0; stab = 0; np = 0;
        acc_pending = 1'b0;
        prev = 96'd0;
        bus.in_pixel = pix4[0];
        bus.in_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (acc_pending && np < 2) begin
                np++;
                bus.in_pixel = pix4[np];
            end
            acc_pending = bus.in_ready;
            if (bus.out_valid) nv++;
            if (bus.in_ready) begin
                nr++;
                if (bus.out_valid) bad++;
            end
            if (bus.out_first) begin
                if (nf < 3) begin
                    check_eq("hold_first_pos", 32'(n), 32'(4 + 10 * nf));
                    check_eq("hold_R", bus.R, exp4r[nf]);
                    check_eq("hold_G", bus.G, exp4g[nf]);
                    check_eq("hold_B", bus.B, exp4b[nf]);
                    check_eq("hold_cnt", 32'(bus.pix_cnt), 32'(2 + nf));
                end
                nf++;
            end else if (bus.out_valid && {bus.R, bus.G, bus.B} != prev) begin
                stab++;
            end
            prev = {bus.R, bus.G, bus.B};
            step();
        end
        bus.in_valid = 1'b0;
        check_eq("hold_valid_cycles", 32'(nv), 32'd18);
        check_eq("hold_ready_cycles", 32'(nr), 32'd3);
        check_eq("hold_first_count", 32'(nf), 32'd3);
        check_eq("hold_ready_overlap", 32'(bad), 32'd0);
        check_eq("hold_stable", 32'(stab), 32'd0);

        // Backpressure: idle with in_valid low
        for (int n = 0; n < 7; n++) begin
            check_eq("bp_ready", 32'(bus.in_ready), 32'd1);
            check_eq("bp_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        check_eq("bp_cnt", 32'(bus.pix_cnt), 32'd5);
        bus.in_pixel = 24'h03_05_07;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check_eq("bp_accepted", 32'(bus.in_ready), 32'd0);
        step();
        step();
        step();
        check_eq("bp_valid_out", 32'(bus.out_valid), 32'd1);
        check_eq("bp_R", bus.R, 32'h40400000);
        check_eq("bp_B", bus.B, 32'h40E00000);

        // Reset mid-hold
        step();
        step();
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        step();
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_R", bus.R, 32'd0);
        check_eq("mid_rst_G", bus.G, 32'd0);
        check_eq("mid_rst_B", bus.B, 32'd0);
        check_eq("mid_rst_cnt", 32'(bus.pix_cnt), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check_eq("mid_rel_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Frame wrap on the 2x2 instance
        nf = 0; nfd = 0; fd_pos = -1;
        bus2.in_pixel = 24'h01_01_01;
        bus2.in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (bus2.out_first) begin
                check_eq("wrap_cnt", 32'(bus2.pix_cnt), 32'(nf % 4));
                nf++;
            end
            if (bus2.frame_done) begin
                nfd++;
                fd_pos = n;
                check_eq("wrap_fd_valid", 32'(bus2.out_valid), 32'd1);
            end
            step();
        end
        bus2.in_valid = 1'b0;
        check_eq("wrap_pixels", 32'(nf), 32'd5);
        check_eq("wrap_fd_count", 32'(nfd), 32'd1);
        check_eq("wrap_fd_pos", 32'(fd_pos), 32'd39);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
